// File: rtl/dut_vec_sequencer.sv
// Sequencer feeding the DUT I/O unpack block: scatters host words into the DUT input vector,
// steps the DUT a programmed number of cycles, snapshots the outputs and streams them back.
module dut_vec_sequencer #(
  parameter int dut_input_width  = 256,
  parameter int dut_output_width = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] run_cycles,
  output logic        busy,
  output logic        done,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dut_input_vec_addr,
  output logic [31:0] dut_input_vec_from_axi,
  output logic        input_vec_en,
  output logic        input_vec_mode,
  output logic [31:0] dut_output_vec_addr,
  output logic        output_vec_en,
  output logic        output_vec_mode,
  input  logic [31:0] dut_output_vec_to_axi,
  output logic        dut_step
);

  localparam int IN_WORDS  = (dut_input_width + 31) / 32;
  localparam int OUT_WORDS = (dut_output_width + 31) / 32;
  localparam int IN_IW     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int OUT_IW    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int OUT_REM   = dut_output_width - 32 * (OUT_WORDS - 1);
  // Clears the padding bits of the final output word that lie above dut_output_width.
  localparam logic [31:0] LAST_MASK = 32'hFFFF_FFFF >> (32 - OUT_REM);
  localparam logic [IN_IW-1:0]  LAST_IN  = IN_IW'(IN_WORDS - 1);
  localparam logic [OUT_IW-1:0] LAST_OUT = OUT_IW'(OUT_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, SNAP, RD, WT} state_t;

  state_t state, state_nxt;
  logic [31:0]       rc;
  logic [IN_IW-1:0]  in_idx;
  logic [OUT_IW-1:0] out_idx;

  always_comb begin
    state_nxt              = state;
    busy                   = (state != IDLE);
    done                   = 1'b0;
    in_ready               = 1'b0;
    input_vec_en           = 1'b0;
    input_vec_mode         = 1'b0;
    dut_input_vec_addr     = 32'h0;
    dut_input_vec_from_axi = 32'h0;
    output_vec_en          = 1'b0;
    output_vec_mode        = 1'b0;
    dut_output_vec_addr    = 32'h0;
    dut_step               = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready     = 1'b1;
        input_vec_en = in_valid;
        if (in_valid) begin
          input_vec_mode         = 1'b1;
          dut_input_vec_addr     = 32'(in_idx);
          dut_input_vec_from_axi = in_word;
          if (in_idx == LAST_IN) state_nxt = (rc == 32'h0) ? SNAP : RUN;
        end
      end
      RUN: begin
        dut_step = 1'b1;
        if (rc <= 32'h1) state_nxt = SNAP;
      end
      SNAP: begin
        output_vec_en   = 1'b1;
        output_vec_mode = 1'b1;
        state_nxt       = RD;
      end
      RD: begin
        output_vec_en       = 1'b1;
        dut_output_vec_addr = 32'(out_idx);
        state_nxt           = WT;
      end
      WT: begin
        if (out_ready) begin
          if (out_idx == LAST_OUT) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rc        <= 32'h0;
      in_idx    <= '0;
      out_idx   <= '0;
      out_word  <= 32'h0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          rc     <= run_cycles;
          in_idx <= '0;
        end
        LOAD: if (in_valid && in_idx != LAST_IN) in_idx <= in_idx + IN_IW'(1);
        RUN:  rc <= rc - 32'h1;
        SNAP: out_idx <= '0;
        // The selected lane is captured as WT is entered and held until the host takes it.
        RD: begin
          out_word  <= dut_output_vec_to_axi & ((out_idx == LAST_OUT) ? LAST_MASK : 32'hFFFF_FFFF);
          out_valid <= 1'b1;
        end
        WT: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_idx != LAST_OUT) out_idx <= out_idx + OUT_IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_vec_sequencer.sv
// Scoreboard bench for dut_vec_sequencer: a 256/256 instance and a 40/33 instance, each wired to
// a small model of the DUT plus unpack buffer (output lane = input lane + steps taken).
module tb_dut_vec_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] run_cycles = 32'h0;
  logic [31:0] in_word = 32'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        busy_a, done_a, in_ready_a, out_valid_a, in_en_a, in_mode_a, out_en_a, out_mode_a, step_a;
  logic [31:0] out_word_a, in_addr_a, in_data_a, out_addr_a, to_axi_a;
  logic        busy_b, done_b, in_ready_b, out_valid_b, in_en_b, in_mode_b, out_en_b, out_mode_b, step_b;
  logic [31:0] out_word_b, in_addr_b, in_data_b, out_addr_b, to_axi_b;

  always #5 clk = ~clk;

  dut_vec_sequencer #(.dut_input_width(256), .dut_output_width(256)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .run_cycles(run_cycles), .busy(busy_a), .done(done_a),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_a), .out_word(out_word_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .dut_input_vec_addr(in_addr_a),
    .dut_input_vec_from_axi(in_data_a), .input_vec_en(in_en_a), .input_vec_mode(in_mode_a),
    .dut_output_vec_addr(out_addr_a), .output_vec_en(out_en_a), .output_vec_mode(out_mode_a),
    .dut_output_vec_to_axi(to_axi_a), .dut_step(step_a));

  dut_vec_sequencer #(.dut_input_width(40), .dut_output_width(33)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .run_cycles(run_cycles), .busy(busy_b), .done(done_b),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_b), .out_word(out_word_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .dut_input_vec_addr(in_addr_b),
    .dut_input_vec_from_axi(in_data_b), .input_vec_en(in_en_b), .input_vec_mode(in_mode_b),
    .dut_output_vec_addr(out_addr_b), .output_vec_en(out_en_b), .output_vec_mode(out_mode_b),
    .dut_output_vec_to_axi(to_axi_b), .dut_step(step_b));

  // DUT + unpack buffer models: the snapshot freezes each input lane plus the number of steps taken.
  logic [31:0] in_vec_a [8];
  logic [31:0] snap_a [8];
  logic [31:0] steps_a = 32'h0;
  logic [31:0] in_vec_b [2];
  logic [31:0] snap_b [2];
  logic [31:0] steps_b = 32'h0;

  always @(posedge clk) begin
    if (in_en_a) in_vec_a[in_addr_a[2:0]] <= in_data_a;
    if (start_a) steps_a <= 32'h0;
    else if (step_a) steps_a <= steps_a + 32'h1;
    if (out_en_a && out_mode_a) for (int i = 0; i < 8; i++) snap_a[i] <= in_vec_a[i] + steps_a;
    if (in_en_b) in_vec_b[in_addr_b[0]] <= in_data_b;
    if (start_b) steps_b <= 32'h0;
    else if (step_b) steps_b <= steps_b + 32'h1;
    if (out_en_b && out_mode_b) for (int i = 0; i < 2; i++) snap_b[i] <= in_vec_b[i] + steps_b;
  end

  assign to_axi_a = (out_addr_a < 32'd8) ? snap_a[out_addr_a[2:0]] : 32'h0;
  assign to_axi_b = (out_addr_b < 32'd2) ? snap_b[out_addr_b[0]] : 32'h0;

  logic sel_b = 1'b0;
  wire        cur_in_ready  = sel_b ? in_ready_b  : in_ready_a;
  wire        cur_in_en     = sel_b ? in_en_b     : in_en_a;
  wire        cur_in_mode   = sel_b ? in_mode_b   : in_mode_a;
  wire [31:0] cur_in_addr   = sel_b ? in_addr_b   : in_addr_a;
  wire        cur_out_valid = sel_b ? out_valid_b : out_valid_a;
  wire [31:0] cur_out_word  = sel_b ? out_word_b  : out_word_a;
  wire        cur_out_en    = sel_b ? out_en_b    : out_en_a;
  wire        cur_out_mode  = sel_b ? out_mode_b  : out_mode_a;
  wire        cur_step      = sel_b ? step_b      : step_a;
  wire        cur_done      = sel_b ? done_b      : done_a;
  wire        cur_busy      = sel_b ? busy_b      : busy_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int in_expect_idx = 0;
  int step_seen = 0;
  int done_total = 0;
  int hold_cnt = 0;
  bit stall_out = 1'b0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Host sink: either always ready, or holds off for four cycles on every presented word.
  always @(posedge clk) begin
    #1;
    if (!stall_out) out_ready = 1'b1;
    else if (cur_out_valid && hold_cnt < 4) begin
      out_ready = 1'b0;
      hold_cnt++;
    end else if (cur_out_valid) out_ready = 1'b1;
    else begin
      out_ready = 1'b0;
      hold_cnt = 0;
    end
  end

  // Monitor: lane-write order, step count, done pulses and the output scoreboard.
  always @(negedge clk) begin
    if (cur_in_en) begin
      checkOutput("in_mode", 32'(cur_in_mode), 32'd1);
      checkOutput("in_addr", cur_in_addr, 32'(in_expect_idx));
      in_expect_idx++;
    end
    if (cur_step) step_seen++;
    if (cur_done) done_total++;
    if (cur_out_valid) begin
      if (out_ready) begin
        checkOutput("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) checkOutput("out_word", cur_out_word, exp_q.pop_front());
      end else if (exp_q.size() > 0) begin
        checkOutput("out_hold", cur_out_word, exp_q[0]);
      end
    end
  end

  task automatic applyStimulus(input bit b, input int rc, input bit stall_in, input bit fixed_words,
                               input int abort_at);
    int n;
    int budget;
    int start_cyc;
    int lat;
    int done_before;
    bit hs;
    logic [31:0] words [8];
    n = b ? 2 : 8;
    sel_b = b;
    step_seen = 0;
    in_expect_idx = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      words[i] = fixed_words ? 32'h11 * 32'(i + 1) : $urandom;
      exp_q.push_back((words[i] + 32'(rc)) & ((b && i == 1) ? 32'h1 : 32'hFFFF_FFFF));
    end
    @(posedge clk); #1;
    run_cycles = 32'(rc);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (stall_in) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_word = words[i];
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 100) begin
        @(negedge clk);
        hs = cur_in_ready;
        @(posedge clk); #1;
        budget++;
      end
      checkOutput("load_hs", 32'(hs), 32'd1);
    end
    in_valid = 1'b0;
    if (rc == 0) begin
      @(negedge clk);
      checkOutput("snap_after_load", 32'({cur_out_en, cur_out_mode}), 32'd3);
    end
    if (abort_at > 0) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!cur_step && budget < 100);
      done_before = done_total;
      repeat (abort_at - 1) begin
        @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", 32'(cur_busy), 32'd0);
      checkOutput("abort_step", 32'(cur_step), 32'd0);
      checkOutput("abort_steps_seen", 32'(step_seen), 32'(abort_at));
      repeat (5) @(negedge clk);
      checkOutput("abort_no_done", 32'(done_total), 32'(done_before));
      exp_q.delete();
      return;
    end
    budget = 0;
    while (!cur_done && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    lat = cyc - start_cyc + 1;
    checkOutput("done_seen", 32'(cur_done), 32'd1);
    if (!stall_in && !stall_out) checkOutput("latency", 32'(lat), 32'(n + rc + 1 + 2 * n));
    @(negedge clk);
    checkOutput("done_pulse", 32'(cur_done), 32'd0);
    checkOutput("idle_after", 32'(cur_busy), 32'd0);
    checkOutput("step_count", 32'(step_seen), 32'(rc));
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ctrl", 32'({busy_a, done_a, in_ready_a, out_valid_a, in_en_a, in_mode_a,
                                  out_en_a, out_mode_a, step_a}), 32'd0);
    checkOutput("rst_out_word", out_word_a, 32'h0);
    checkOutput("rst_addr", in_addr_a | in_data_a | out_addr_a, 32'h0);
    checkOutput("rst_b_ctrl", 32'({busy_b, done_b, out_valid_b, step_b}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_no_start", 32'({busy_a, in_ready_a, step_a}), 32'd0);

    applyStimulus(1'b0, 5, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 0);
    stall_out = 1'b1;
    applyStimulus(1'b0, 3, 1'b1, 1'b0, 0);
    stall_out = 1'b0;
    applyStimulus(1'b1, 4, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 10, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 2, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
